// File: rtl/io_timer.sv
// io_timer: memory-mapped timer/counter on its own 4 KiB I/O page.
//
// Ports:
//   i_clk    - system clock, all state on rising edge
//   i_reset  - asynchronous active-low reset
//   i_addr   - byte address from the LSU; register select is i_addr[4:2]
//   i_wdata  - lane-aligned store data
//   i_bmask  - byte-lane write enables
//   i_wren   - store strobe, qualified internally by the page hit
//   o_sel    - combinational page hit
//   o_rdata  - combinational read data, 0 when o_sel is low
//   o_irq    - level interrupt, IRQ_EN & (MATCH | OVF)
//
// Register map: 0x00 CTRL {PRESCALE[15:8], IRQ_EN[2], AUTO_RELOAD[1], EN[0]},
// 0x04 COUNT, 0x08 COMPARE, 0x0C STATUS {OVF[1], MATCH[0]} (W1C via lane 0),
// 0x10-0x1C reserved.
module io_timer #(
  parameter logic [31:0] BASE_ADDR = 32'h1000_5000
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wdata,
  input  logic [3:0]  i_bmask,
  input  logic        i_wren,
  output logic        o_sel,
  output logic [31:0] o_rdata,
  output logic        o_irq
);

  localparam logic [2:0] REG_CTRL    = 3'd0;
  localparam logic [2:0] REG_COUNT   = 3'd1;
  localparam logic [2:0] REG_COMPARE = 3'd2;
  localparam logic [2:0] REG_STATUS  = 3'd3;

  // Byte-lane merge of a store into an existing register value.
  function automatic logic [31:0] merge_bytes(
    input logic [31:0] old_val,
    input logic [31:0] wdata,
    input logic [3:0]  bmask
  );
    logic [31:0] res;
    res = old_val;
    for (int b = 0; b < 4; b++) begin
      if (bmask[b]) res[8*b +: 8] = wdata[8*b +: 8];
    end
    return res;
  endfunction

  // Wrapping increment; bit 32 flags the FFFF_FFFF -> 0 wrap.
  function automatic logic [32:0] count_inc(input logic [31:0] val);
    return {1'b0, val} + 33'd1;
  endfunction

  logic        en;
  logic        auto_reload;
  logic        irq_en;
  logic [7:0]  prescale;
  logic [31:0] count;
  logic [31:0] compare;
  logic        match;
  logic        ovf;
  logic [7:0]  prs;

  logic [2:0]  reg_sel;
  logic        wr_ctrl;
  logic        wr_count;
  logic        wr_compare;
  logic        wr_status;
  logic [31:0] ctrl_word;
  logic [31:0] ctrl_new;
  logic        tick;
  logic        is_match;
  logic [32:0] cnt_inc;
  logic        set_match;
  logic        set_ovf;
  logic        clr_match;
  logic        clr_ovf;

  assign o_sel   = (i_addr[31:12] == BASE_ADDR[31:12]);
  assign reg_sel = i_addr[4:2];

  always_comb begin
    wr_ctrl    = i_wren & o_sel & (reg_sel == REG_CTRL);
    wr_count   = i_wren & o_sel & (reg_sel == REG_COUNT);
    wr_compare = i_wren & o_sel & (reg_sel == REG_COMPARE);
    wr_status  = i_wren & o_sel & (reg_sel == REG_STATUS);

    ctrl_word  = {16'd0, prescale, 5'd0, irq_en, auto_reload, en};
    ctrl_new   = merge_bytes(ctrl_word, i_wdata, i_bmask);

    // >= so that lowering PRESCALE below the running prs ticks at once.
    tick       = en & (prs >= prescale);
    is_match   = (count == compare);
    cnt_inc    = count_inc(count);

    // A COUNT store on a tick cycle suppresses match/overflow evaluation.
    set_match  = tick & ~wr_count & is_match;
    set_ovf    = tick & ~wr_count & ~(is_match & auto_reload) & cnt_inc[32];

    clr_match  = wr_status & i_bmask[0] & i_wdata[0];
    clr_ovf    = wr_status & i_bmask[0] & i_wdata[1];
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      en          <= 1'b0;
      auto_reload <= 1'b0;
      irq_en      <= 1'b0;
      prescale    <= 8'd0;
    end else if (wr_ctrl) begin
      en          <= ctrl_new[0];
      auto_reload <= ctrl_new[1];
      irq_en      <= ctrl_new[2];
      prescale    <= ctrl_new[15:8];
    end
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      prs <= 8'd0;
    end else if (!en || (wr_ctrl && !ctrl_new[0]) || tick) begin
      prs <= 8'd0;
    end else begin
      prs <= prs + 8'd1;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      count <= 32'd0;
    end else if (wr_count) begin
      count <= merge_bytes(count, i_wdata, i_bmask);
    end else if (tick) begin
      count <= (is_match && auto_reload) ? 32'd0 : cnt_inc[31:0];
    end
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      compare <= 32'd0;
    end else if (wr_compare) begin
      compare <= merge_bytes(compare, i_wdata, i_bmask);
    end
  end

  // Set beats clear when both land on the same edge.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      match <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      match <= set_match | (match & ~clr_match);
      ovf   <= set_ovf | (ovf & ~clr_ovf);
    end
  end

  always_comb begin
    o_rdata = 32'd0;
    if (o_sel) begin
      case (reg_sel)
        REG_CTRL:    o_rdata = ctrl_word;
        REG_COUNT:   o_rdata = count;
        REG_COMPARE: o_rdata = compare;
        REG_STATUS:  o_rdata = {30'd0, ovf, match};
        default:     o_rdata = 32'd0;
      endcase
    end
  end

  assign o_irq = irq_en & (match | ovf);

endmodule

// File: tb/tb_io_timer.sv
module tb_io_timer;

  localparam logic [31:0] A_CTRL    = 32'h1000_5000;
  localparam logic [31:0] A_COUNT   = 32'h1000_5004;
  localparam logic [31:0] A_COMPARE = 32'h1000_5008;
  localparam logic [31:0] A_STATUS  = 32'h1000_500C;
  localparam logic [31:0] A_RSVD    = 32'h1000_5014;
  localparam logic [31:0] A_FOREIGN = 32'h1000_6004;

  logic        i_clk;
  logic        i_reset;
  logic [31:0] i_addr;
  logic [31:0] i_wdata;
  logic [3:0]  i_bmask;
  logic        i_wren;
  logic        o_sel;
  logic [31:0] o_rdata;
  logic        o_irq;

  int checks = 0;
  int errors = 0;

  io_timer #(.BASE_ADDR(32'h1000_5000)) dut (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_addr  (i_addr),
    .i_wdata (i_wdata),
    .i_bmask (i_bmask),
    .i_wren  (i_wren),
    .o_sel   (o_sel),
    .o_rdata (o_rdata),
    .o_irq   (o_irq)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  typedef struct {
    string       name;
    logic        chk_data;
    logic        sel;
    logic [31:0] rdata;
  } sb_t;

  sb_t sbq[$];

  typedef struct {
    string       name;
    logic        is_wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  bmask;
    logic        exp_sel;
    logic [31:0] exp_rdata;
  } vec_t;

  // Pops the oldest expectation and compares against the live outputs.
  task automatic sb_check();
    sb_t e;
    e = sbq.pop_front();
    checks++;
    if (o_sel !== e.sel) begin
      errors++;
      $display("FAIL %s sel: got %0b expected %0b", e.name, o_sel, e.sel);
    end
    if (e.chk_data) begin
      checks++;
      if (o_rdata !== e.rdata) begin
        errors++;
        $display("FAIL %s rdata: got %08h expected %08h", e.name, o_rdata, e.rdata);
      end
    end
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] exp, input string name);
    sb_t e;
    i_wren = 1'b0;
    i_addr = a;
    #1;
    e.name = name; e.chk_data = 1'b1; e.sel = (a[31:12] == 20'h10005); e.rdata = exp;
    sbq.push_back(e);
    sb_check();
  endtask

  // Drives a store that is sampled on the next rising edge; returns at the
  // following falling edge with the strobe dropped.
  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
    i_addr  = a;
    i_wdata = d;
    i_bmask = m;
    i_wren  = 1'b1;
    @(negedge i_clk);
    i_wren  = 1'b0;
  endtask

  task automatic chk_bit(input logic act, input logic exp, input string name);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0b expected %0b", name, act, exp);
    end
  endtask

  task automatic chk_irq(input logic exp, input string name);
    i_wren = 1'b0;
    #1;
    chk_bit(o_irq, exp, name);
  endtask

  vec_t vecs[$];

  task automatic add_vec(input string n, input logic w, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] m,
                         input logic s, input logic [31:0] r);
    vec_t v;
    v.name = n; v.is_wr = w; v.addr = a; v.wdata = d; v.bmask = m;
    v.exp_sel = s; v.exp_rdata = r;
    vecs.push_back(v);
  endtask

  initial begin
    i_reset = 1'b0;
    i_addr  = 32'd0;
    i_wdata = 32'd0;
    i_bmask = 4'd0;
    i_wren  = 1'b0;

    add_vec("rst_ctrl",    1'b0, A_CTRL,    32'd0, 4'h0, 1'b1, 32'd0);
    add_vec("rst_count",   1'b0, A_COUNT,   32'd0, 4'h0, 1'b1, 32'd0);
    add_vec("rst_compare", 1'b0, A_COMPARE, 32'd0, 4'h0, 1'b1, 32'd0);
    add_vec("rst_status",  1'b0, A_STATUS,  32'd0, 4'h0, 1'b1, 32'd0);
    add_vec("w_ctrl",      1'b1, A_CTRL,    32'hFFFF_FFFE, 4'hF, 1'b1, 32'd0);
    add_vec("ctrl_mask",   1'b0, A_CTRL,    32'd0, 4'h0, 1'b1, 32'h0000_FF06);
    add_vec("w_cmp_bm",    1'b1, A_COMPARE, 32'hDEAD_BEEF, 4'b0101, 1'b1, 32'd0);
    add_vec("cmp_bmask",   1'b0, A_COMPARE, 32'd0, 4'h0, 1'b1, 32'h00AD_00EF);
    add_vec("w_count",     1'b1, A_COUNT,   32'h1234_5678, 4'hF, 1'b1, 32'd0);
    add_vec("count_rb",    1'b0, A_COUNT,   32'd0, 4'h0, 1'b1, 32'h1234_5678);
    add_vec("w_status",    1'b1, A_STATUS,  32'hFFFF_FFFF, 4'hF, 1'b1, 32'd0);
    add_vec("status_rb",   1'b0, A_STATUS,  32'd0, 4'h0, 1'b1, 32'd0);
    add_vec("rsvd_rd",     1'b0, A_RSVD,    32'd0, 4'h0, 1'b1, 32'd0);
    add_vec("w_foreign",   1'b1, A_FOREIGN, 32'hCAFE_0001, 4'hF, 1'b0, 32'd0);
    add_vec("foreign_rd",  1'b0, A_FOREIGN, 32'd0, 4'h0, 1'b0, 32'd0);
    add_vec("count_kept",  1'b0, A_COUNT,   32'd0, 4'h0, 1'b1, 32'h1234_5678);
    add_vec("w_ctrl_clr",  1'b1, A_CTRL,    32'd0, 4'hF, 1'b1, 32'd0);
    add_vec("ctrl_clr",    1'b0, A_CTRL,    32'd0, 4'h0, 1'b1, 32'd0);

    @(negedge i_clk);
    @(negedge i_clk);
    chk_irq(1'b0, "rst_irq");
    i_reset = 1'b1;

    // Register access table.
    foreach (vecs[k]) begin
      sb_t e;
      i_addr  = vecs[k].addr;
      i_wdata = vecs[k].wdata;
      i_bmask = vecs[k].bmask;
      i_wren  = vecs[k].is_wr;
      #1;
      e.name = vecs[k].name; e.chk_data = ~vecs[k].is_wr | ~vecs[k].exp_sel;
      e.sel = vecs[k].exp_sel; e.rdata = vecs[k].exp_rdata;
      sbq.push_back(e);
      sb_check();
      if (vecs[k].is_wr) begin
        @(negedge i_clk);
        i_wren = 1'b0;
      end
    end

    // Prescale cadence: PRESCALE=3, EN written at edge 0.
    wr(A_COUNT, 32'd0, 4'hF);
    wr(A_CTRL, 32'h0000_0301, 4'hF);
    rd(A_COUNT, 32'd0, "ps_e0");
    for (int e = 1; e <= 12; e++) begin
      @(negedge i_clk);
      rd(A_COUNT, 32'(e / 4), $sformatf("ps_e%0d", e));
    end
    wr(A_CTRL, 32'd0, 4'hF);
    rd(A_COUNT, 32'd3, "ps_stop");
    @(negedge i_clk);
    @(negedge i_clk);
    rd(A_COUNT, 32'd3, "ps_frozen");

    // Match with auto-reload, IRQ enabled, PRESCALE=0.
    wr(A_STATUS, 32'd3, 4'h1);
    wr(A_COUNT, 32'd0, 4'hF);
    wr(A_COMPARE, 32'd5, 4'hF);
    wr(A_CTRL, 32'h0000_0007, 4'hF);
    rd(A_COUNT, 32'd0, "ar_e0");
    for (int e = 1; e <= 8; e++) begin
      @(negedge i_clk);
      rd(A_COUNT, (e <= 5) ? 32'(e) : 32'(e - 6), $sformatf("ar_cnt_e%0d", e));
      rd(A_STATUS, (e >= 6) ? 32'd1 : 32'd0, $sformatf("ar_st_e%0d", e));
      chk_irq(e >= 6, $sformatf("ar_irq_e%0d", e));
    end
    wr(A_STATUS, 32'd1, 4'h1);
    rd(A_STATUS, 32'd0, "ar_w1c");
    chk_irq(1'b0, "ar_irq_clr");
    wr(A_CTRL, 32'd0, 4'hF);
    rd(A_COUNT, 32'd4, "ar_stop");

    // Overflow: FFFF_FFFE -> FFFF_FFFF -> 0 with OVF, no MATCH.
    wr(A_COUNT, 32'hFFFF_FFFE, 4'hF);
    wr(A_COMPARE, 32'h10, 4'hF);
    wr(A_CTRL, 32'h0000_0001, 4'hF);
    @(negedge i_clk);
    rd(A_COUNT, 32'hFFFF_FFFF, "ovf_t1");
    rd(A_STATUS, 32'd0, "ovf_st_t1");
    @(negedge i_clk);
    rd(A_COUNT, 32'd0, "ovf_t2");
    rd(A_STATUS, 32'd2, "ovf_st_t2");
    chk_irq(1'b0, "ovf_irq_off");
    wr(A_CTRL, 32'd0, 4'hF);
    rd(A_COUNT, 32'd1, "ovf_stop");

    // COUNT write colliding with a tick.
    wr(A_STATUS, 32'd3, 4'h1);
    wr(A_COMPARE, 32'hFFFF_0000, 4'hF);
    wr(A_COUNT, 32'h50, 4'hF);
    wr(A_CTRL, 32'h0000_0001, 4'hF);
    @(negedge i_clk);
    rd(A_COUNT, 32'h51, "cw_run");
    wr(A_COUNT, 32'h100, 4'hF);
    rd(A_COUNT, 32'h100, "cw_collide");
    wr(A_CTRL, 32'd0, 4'hF);
    rd(A_COUNT, 32'h101, "cw_stop");

    // W1C of MATCH on the same edge as a new match.
    wr(A_COMPARE, 32'd1, 4'hF);
    wr(A_COUNT, 32'd1, 4'hF);
    wr(A_STATUS, 32'd3, 4'h1);
    wr(A_CTRL, 32'h0000_0003, 4'hF);
    @(negedge i_clk);
    rd(A_STATUS, 32'd1, "wc_first");
    rd(A_COUNT, 32'd0, "wc_reload");
    @(negedge i_clk);
    rd(A_COUNT, 32'd1, "wc_pre");
    wr(A_STATUS, 32'd1, 4'h1);
    rd(A_STATUS, 32'd1, "wc_set_wins");
    rd(A_COUNT, 32'd0, "wc_reload2");
    wr(A_CTRL, 32'h0000_0004, 4'hF);
    rd(A_COUNT, 32'd1, "wc_old_ctrl");
    chk_irq(1'b1, "wc_irq");
    @(negedge i_clk);
    @(negedge i_clk);
    rd(A_COUNT, 32'd1, "wc_frozen");

    // Asynchronous reset mid-run.
    wr(A_CTRL, 32'h0000_0005, 4'hF);
    chk_irq(1'b1, "mr_irq_pre");
    i_reset = 1'b0;
    chk_irq(1'b0, "mr_irq");
    rd(A_CTRL, 32'd0, "mr_ctrl");
    rd(A_COUNT, 32'd0, "mr_count");
    rd(A_COMPARE, 32'd0, "mr_compare");
    rd(A_STATUS, 32'd0, "mr_status");
    @(negedge i_clk);
    i_reset = 1'b1;
    @(negedge i_clk);
    rd(A_COUNT, 32'd0, "mr_after");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
